approx_product_accumulator: RTL and testbench
=============================================

Name: approx_product_accumulator

Overview:
- Downstream consumer of the 8x8 approximate column-truncated multiplier stage. Accepts its 16-bit products one per cycle, tagged with a vector-end marker.
- Accumulates each vector of products into a wider saturating sum.
- Presents the per-vector dot-product result, element count and overflow flag on a valid/ready output port.
- Sits between the approximate multiplier array and the layer's activation/writeback logic.

Parameters:
- PROD_W, 16, width of incoming product (matches the 8x8 multiplier output)
- ACC_W, 24, accumulator and result width; must be >= PROD_W
- CNT_W, 8, element-counter width

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  product valid
- in_ready  output  1  block can accept a product this cycle
- in_prod  input  PROD_W  unsigned product from the approximate multiplier
- in_last  input  1  product is the final element of the current vector
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts the result
- out_sum  output  ACC_W  accumulated unsigned sum of the vector
- out_count  output  CNT_W  number of products accepted in the vector
- out_ovf  output  1  sum saturated at some point in the vector

Behaviour:
- Reset (rst=1 at a clock edge):
  - state<=IDLE; acc<=0; cnt<=0; ovf<=0.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0; in_ready=1 on the first cycle after reset.
  - Reset has priority over every other event. Reset mid-vector or while holding a result discards everything; no result is emitted.
- Transfer rules:
  - Input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready.
  - in_prod and in_last are ignored when no input transfer occurs.
- States:
  - IDLE: acc=0, cnt=0, ovf=0. On input transfer:
    - acc<=in_prod; cnt<=1.
    - Go to HOLD if in_last, else go to ACCUM.
  - ACCUM: on input transfer:
    - acc<=sat(acc+in_prod); cnt<=sat(cnt+1).
    - ovf<=ovf | carry out of the ACC_W-bit add.
    - Go to HOLD if in_last, else stay in ACCUM.
    - No transfer: hold all state (bubbles are allowed).
  - HOLD:
    - in_ready=0; out_valid=1; out_sum=acc; out_count=cnt; out_ovf=ovf. All outputs are stable until transfer.
    - On output transfer: acc<=0, cnt<=0, ovf<=0, state<=IDLE.
- in_ready = (state != HOLD). It is purely a state decode, with no combinational path from out_ready.
  - Consequence: the cycle that completes an output transfer cannot also accept an input. The first product of the next vector is accepted at the earliest one cycle after the output transfer.
- Outputs are registered or state-decoded only. out_sum, out_count and out_ovf read 0 whenever out_valid=0.
- Latency: last product accepted at edge t -> out_valid=1 in the cycle after edge t. A single-element vector behaves the same way.
- Arithmetic:
  - in_prod is zero-extended to ACC_W.
  - sat(a+b) = 2^ACC_W-1 if the ACC_W-bit add carries out, else a+b. acc stays at max once saturated.
  - cnt saturates at 2^CNT_W-1 and does not wrap; it does not set ovf.
- Throughput: one product per clock while not in HOLD. The minimum vector period is vector length + 1 cycles when out_ready is held at 1.
- Backpressure: out_ready low holds HOLD indefinitely. in_valid may stay asserted meanwhile; no product is lost or double-counted.

Test Plan:
- Reset, then vector 3, 5, 7 (last on 7), out_ready=1 -> out_valid one cycle after the 7 is accepted, out_sum=15, out_count=3, out_ovf=0; in_ready is 0 for exactly that cycle.
- Single-element vector 65535 with in_last=1 -> out_sum=65535, out_count=1; then vector 1 (last) -> out_sum=1. Confirms acc is cleared between vectors.
- ACC_W=17, vector 65535, 65535, 10 -> out_sum=131071 (saturated), out_ovf=1, out_count=3; the next vector 4 (last) -> out_sum=4, out_ovf=0.
- Bubbles and backpressure: products 100, gap of 2 cycles, 200 (last); hold out_ready=0 for 5 cycles with in_valid=1 and in_prod=9 presented -> out_sum=300 stable all 5 cycles, in_ready=0. After release, the 9 is accepted one cycle after the output transfer.
- Reset asserted after products 50, 60 (no last) -> no out_valid; post-reset vector 1, 2 (last) -> out_sum=3, out_count=2.
- Back-to-back: 256 consecutive products of value 1 with last on the 256th, CNT_W=8 -> out_count=255 (saturated), out_sum=256.

Source files
------------

// File: rtl/approx_product_accumulator.sv
// Accumulates vectors of unsigned products from the approximate multiplier into a
// saturating sum and hands back sum, element count and overflow flag over valid/ready.
module approx_product_accumulator #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ovf, ovf_nxt;
    logic [ACC_W-1:0] prod_ext;
    logic             in_xfer;
    logic             out_xfer;

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    function automatic logic add_carry(input logic [ACC_W-1:0] a,
                                       input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ACC_W];
    endfunction

    // Count sticks at all-ones instead of wrapping; it never feeds the overflow flag.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    assign prod_ext = ACC_W'(in_prod);
    assign in_ready = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    assign out_sum   = out_valid ? acc : '0;
    assign out_count = out_valid ? cnt : '0;
    assign out_ovf   = out_valid & ovf;

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf;
        case (state)
            IDLE: begin
                if (in_xfer) begin
                    acc_nxt   = prod_ext;
                    cnt_nxt   = CNT_W'(1);
                    ovf_nxt   = 1'b0;
                    state_nxt = in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (in_xfer) begin
                    acc_nxt   = sat_add(acc, prod_ext);
                    cnt_nxt   = sat_inc(cnt);
                    ovf_nxt   = ovf | add_carry(acc, prod_ext);
                    state_nxt = in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                // Input is blocked here, so the handoff cycle never starts a new vector.
                if (out_xfer) begin
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    ovf_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                acc_nxt   = '0;
                cnt_nxt   = '0;
                ovf_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            ovf   <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_approx_product_accumulator.sv
// Bench for approx_product_accumulator: two widths (ACC_W=24 and 17) share one stimulus
// stream and are compared every cycle against a queue-based vector model.
module tb_approx_product_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_prod;
    logic        in_last;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_ovf_a;
    logic [23:0] out_sum_a;
    logic [7:0]  out_count_a;
    logic        in_ready_b, out_valid_b, out_ovf_b;
    logic [16:0] out_sum_b;
    logic [7:0]  out_count_b;

    int tests = 0;
    int fails = 0;

    longint unsigned q_prods[$];
    bit              m_hold = 1'b0;

    always #5 clk = ~clk;

    approx_product_accumulator #(.PROD_W(16), .ACC_W(24), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_sum(out_sum_a), .out_count(out_count_a),
        .out_ovf(out_ovf_a)
    );

    approx_product_accumulator #(.PROD_W(16), .ACC_W(17), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_sum(out_sum_b), .out_count(out_count_b),
        .out_ovf(out_ovf_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint unsigned m_total();
        longint unsigned t = 0;
        foreach (q_prods[i]) t += q_prods[i];
        return t;
    endfunction

    // Expected result for an accumulator of width w: clipped true sum, overflow when clipped.
    task automatic check_outputs();
        longint unsigned tot, max_a, max_b, cnt;
        tot   = m_total();
        max_a = (64'd1 << 24) - 1;
        max_b = (64'd1 << 17) - 1;
        cnt   = (q_prods.size() > 255) ? 255 : q_prods.size();
        check("a_in_ready",  in_ready_a,  !m_hold);
        check("a_out_valid", out_valid_a, m_hold);
        check("a_out_sum",   out_sum_a,   m_hold ? ((tot > max_a) ? max_a : tot) : 0);
        check("a_out_count", out_count_a, m_hold ? cnt : 0);
        check("a_out_ovf",   out_ovf_a,   m_hold && (tot > max_a));
        check("b_in_ready",  in_ready_b,  !m_hold);
        check("b_out_valid", out_valid_b, m_hold);
        check("b_out_sum",   out_sum_b,   m_hold ? ((tot > max_b) ? max_b : tot) : 0);
        check("b_out_count", out_count_b, m_hold ? cnt : 0);
        check("b_out_ovf",   out_ovf_b,   m_hold && (tot > max_b));
    endtask

    task automatic cycle(input bit r_st, input bit v, input logic [15:0] p,
                         input bit l, input bit r);
        bit in_x, out_x;
        rst       = r_st;
        in_valid  = v;
        in_prod   = p;
        in_last   = l;
        out_ready = r;
        in_x  = v && !m_hold;
        out_x = m_hold && r;
        @(posedge clk);
        #1;
        if (r_st) begin
            q_prods.delete();
            m_hold = 1'b0;
        end else if (out_x) begin
            q_prods.delete();
            m_hold = 1'b0;
        end else if (in_x) begin
            q_prods.push_back(longint'(p));
            if (l) m_hold = 1'b1;
        end
        check_outputs();
    endtask

    task automatic send(input logic [15:0] p, input bit l);
        cycle(1'b0, 1'b1, p, l, 1'b1);
    endtask

    task automatic idle(input bit r);
        cycle(1'b0, 1'b0, 16'd0, 1'b0, r);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b0;

        cycle(1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'd77, 1'b1, 1'b0);
        check("rst_in_ready", in_ready_a, 1'b1);
        check("rst_out_sum", out_sum_a, 0);

        // 3, 5, 7
        send(16'd3, 1'b0);
        send(16'd5, 1'b0);
        send(16'd7, 1'b1);
        check("v1_valid", out_valid_a, 1'b1);
        check("v1_sum", out_sum_a, 15);
        check("v1_count", out_count_a, 3);
        check("v1_ready", in_ready_a, 1'b0);
        idle(1'b1);
        check("v1_ready_back", in_ready_a, 1'b1);

        // Single element, then acc must be cleared
        send(16'd65535, 1'b1);
        check("v2_sum", out_sum_a, 65535);
        check("v2_count", out_count_a, 1);
        idle(1'b1);
        send(16'd1, 1'b1);
        check("v3_sum", out_sum_a, 1);
        idle(1'b1);

        // Saturation on the 17-bit instance
        send(16'd65535, 1'b0);
        send(16'd65535, 1'b0);
        send(16'd10, 1'b1);
        check("sat_sum_b", out_sum_b, 131071);
        check("sat_ovf_b", out_ovf_b, 1'b1);
        check("sat_count_b", out_count_b, 3);
        check("sat_sum_a", out_sum_a, 131080);
        idle(1'b1);
        send(16'd4, 1'b1);
        check("post_sat_sum_b", out_sum_b, 4);
        check("post_sat_ovf_b", out_ovf_b, 1'b0);
        idle(1'b1);

        // Bubbles and backpressure
        cycle(1'b0, 1'b1, 16'd100, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        cycle(1'b0, 1'b1, 16'd200, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 16'd9, 1'b1, 1'b0);
            check("bp_sum", out_sum_a, 300);
            check("bp_ready", in_ready_a, 1'b0);
        end
        cycle(1'b0, 1'b1, 16'd9, 1'b1, 1'b1);
        check("bp_released", out_valid_a, 1'b0);
        cycle(1'b0, 1'b1, 16'd9, 1'b1, 1'b1);
        check("bp_nine_sum", out_sum_a, 9);
        check("bp_nine_count", out_count_a, 1);
        idle(1'b1);

        // Reset mid-vector discards the partial sum
        send(16'd50, 1'b0);
        send(16'd60, 1'b0);
        cycle(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
        check("midrst_valid", out_valid_a, 1'b0);
        send(16'd1, 1'b0);
        send(16'd2, 1'b1);
        check("midrst_sum", out_sum_a, 3);
        check("midrst_count", out_count_a, 2);
        idle(1'b1);

        // 256 back-to-back ones: count saturates, sum does not
        for (int i = 0; i < 256; i++) send(16'd1, i == 255);
        check("long_count", out_count_a, 255);
        check("long_sum", out_sum_a, 256);
        idle(1'b1);

        // Random traffic with bubbles, backpressure and large products
        for (int i = 0; i < 400; i++) begin
            logic [15:0] p;
            p = ($urandom_range(0, 3) == 0) ? 16'(65000 + $urandom_range(0, 535))
                                            : 16'($urandom);
            cycle(1'b0, ($urandom_range(0, 3) != 0), p,
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) != 0));
        end
        idle(1'b1);
        idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
